// File: rtl/dbg_guv_multi.sv
// Multi-channel debug governor: pauses, drops or logs flits on NUM_CH AXI-Stream
// channels, configured through a daisy-chained two-flit command stream.
module dbg_guv_multi #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEST_WIDTH  = 16,
  parameter int ID_WIDTH    = 16,
  parameter int CNT_SIZE    = 16,
  parameter int ADDR_WIDTH  = 10,
  parameter int ADDR        = 0,
  parameter int NUM_CH      = 4,
  parameter int STICKY_MODE = 1,
  parameter int PIPE_STAGE  = 0,
  localparam int CH_W  = $clog2(NUM_CH + 1),
  localparam int KW    = DATA_WIDTH / 8,
  localparam int LOG_W = DATA_WIDTH + KW + 1 + DEST_WIDTH + ID_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DATA_WIDTH-1:0]          cmd_in_TDATA,
  input  logic                           cmd_in_TVALID,
  output logic [DATA_WIDTH-1:0]          cmd_out_TDATA,
  output logic                           cmd_out_TVALID,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   in_TDATA,
  input  logic [NUM_CH*KW-1:0]           in_TKEEP,
  input  logic [NUM_CH*DEST_WIDTH-1:0]   in_TDEST,
  input  logic [NUM_CH*ID_WIDTH-1:0]     in_TID,
  input  logic [NUM_CH-1:0]              in_TLAST,
  input  logic [NUM_CH-1:0]              in_TVALID,
  output logic [NUM_CH-1:0]              in_TREADY,
  output logic [NUM_CH*DATA_WIDTH-1:0]   out_TDATA,
  output logic [NUM_CH*KW-1:0]           out_TKEEP,
  output logic [NUM_CH*DEST_WIDTH-1:0]   out_TDEST,
  output logic [NUM_CH*ID_WIDTH-1:0]     out_TID,
  output logic [NUM_CH-1:0]              out_TLAST,
  output logic [NUM_CH-1:0]              out_TVALID,
  input  logic [NUM_CH-1:0]              out_TREADY,
  output logic [NUM_CH*LOG_W-1:0]        log_TDATA,
  output logic [NUM_CH-1:0]              log_TLAST,
  output logic [NUM_CH-1:0]              log_TVALID,
  input  logic [NUM_CH-1:0]              log_TREADY
);

  typedef enum logic [1:0] {IDLE, OURS, THEIRS} cmd_state_t;

  cmd_state_t            state;
  logic [CH_W-1:0]       cmd_ch;
  logic [3:0]            cmd_reg;
  logic                  hdr_ours;
  logic                  fwd;
  logic                  wr_en;
  logic [CNT_SIZE-1:0]   wr_val;
  logic                  unused_cmd_bits;

  assign hdr_ours = (cmd_in_TDATA[ADDR_WIDTH+CH_W+3:CH_W+4] == ADDR_WIDTH'(ADDR));
  assign fwd      = cmd_in_TVALID & (((state == IDLE) & ~hdr_ours) | (state == THEIRS));
  assign wr_en    = cmd_in_TVALID & (state == OURS);
  assign wr_val   = cmd_in_TDATA[CNT_SIZE-1:0];
  assign unused_cmd_bits = ^cmd_in_TDATA;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cmd_ch  <= '0;
      cmd_reg <= '0;
    end else if (cmd_in_TVALID) begin
      case (state)
        IDLE: begin
          if (hdr_ours) begin
            state   <= OURS;
            cmd_ch  <= cmd_in_TDATA[CH_W+3:4];
            cmd_reg <= cmd_in_TDATA[3:0];
          end else begin
            state <= THEIRS;
          end
        end
        OURS:    state <= IDLE;
        THEIRS:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  if (PIPE_STAGE != 0) begin : g_cmd_pipe
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cmd_out_TDATA  <= '0;
        cmd_out_TVALID <= 1'b0;
      end else begin
        cmd_out_TDATA  <= cmd_in_TDATA;
        cmd_out_TVALID <= fwd;
      end
    end
  end else begin : g_cmd_comb
    assign cmd_out_TDATA  = cmd_in_TDATA;
    assign cmd_out_TVALID = fwd;
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [CNT_SIZE-1:0] sh_drop, sh_log, act_drop, act_log;
    logic                sh_pause, sh_logging, sh_dropping;
    logic                act_pause, act_logging, act_dropping;
    logic                log_full;
    logic [LOG_W-1:0]    log_buf;
    logic                sel, latch, pause, drop, logging, space, accept, load;

    assign sel     = wr_en & ((cmd_ch == '1) | (cmd_ch == CH_W'(k)));
    assign latch   = sel & (cmd_reg == 4'd15);
    assign pause   = act_pause;
    assign drop    = act_dropping | (act_drop != '0);
    assign logging = act_logging | (act_log != '0);
    assign space   = ~log_full | log_TREADY[k];
    assign accept  = in_TVALID[k] & in_TREADY[k];
    assign load    = accept & ~drop & logging;

    assign in_TREADY[k]  = ~pause & (drop | (out_TREADY[k] & (~logging | space)));
    assign out_TVALID[k] = in_TVALID[k] & ~pause & ~drop & (~logging | space);
    assign out_TDATA[k*DATA_WIDTH +: DATA_WIDTH] = in_TDATA[k*DATA_WIDTH +: DATA_WIDTH];
    assign out_TKEEP[k*KW +: KW]                 = in_TKEEP[k*KW +: KW];
    assign out_TDEST[k*DEST_WIDTH +: DEST_WIDTH] = in_TDEST[k*DEST_WIDTH +: DEST_WIDTH];
    assign out_TID[k*ID_WIDTH +: ID_WIDTH]       = in_TID[k*ID_WIDTH +: ID_WIDTH];
    assign out_TLAST[k]                          = in_TLAST[k];

    // Latch takes priority over a same-cycle counter decrement.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sh_drop      <= '0;
        sh_log       <= '0;
        sh_pause     <= 1'b0;
        sh_logging   <= 1'b0;
        sh_dropping  <= 1'b0;
        act_drop     <= '0;
        act_log      <= '0;
        act_pause    <= 1'b0;
        act_logging  <= 1'b0;
        act_dropping <= 1'b0;
      end else begin
        if (sel) begin
          case (cmd_reg)
            4'd0: sh_drop     <= wr_val;
            4'd1: sh_log      <= wr_val;
            4'd2: sh_pause    <= wr_val[0];
            4'd3: sh_logging  <= wr_val[0];
            4'd4: sh_dropping <= wr_val[0];
            4'd15: begin
              if (STICKY_MODE == 0) begin
                sh_drop     <= '0;
                sh_log      <= '0;
                sh_pause    <= 1'b0;
                sh_logging  <= 1'b0;
                sh_dropping <= 1'b0;
              end
            end
            default: ;
          endcase
        end
        if (latch) begin
          act_drop     <= sh_drop;
          act_log      <= sh_log;
          act_pause    <= sh_pause;
          act_logging  <= sh_logging;
          act_dropping <= sh_dropping;
        end else begin
          if (accept && drop && (act_drop != '0)) act_drop <= act_drop - CNT_SIZE'(1);
          if (load && (act_log != '0))            act_log  <= act_log - CNT_SIZE'(1);
        end
      end
    end

    // A load in the same cycle as a drain keeps the entry full with the new flit.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        log_full <= 1'b0;
        log_buf  <= '0;
      end else if (load) begin
        log_full <= 1'b1;
        log_buf  <= {in_TID[k*ID_WIDTH +: ID_WIDTH], in_TDEST[k*DEST_WIDTH +: DEST_WIDTH],
                     in_TLAST[k], in_TKEEP[k*KW +: KW], in_TDATA[k*DATA_WIDTH +: DATA_WIDTH]};
      end else if (log_full && log_TREADY[k]) begin
        log_full <= 1'b0;
      end
    end

    assign log_TDATA[k*LOG_W +: LOG_W] = log_buf;
    assign log_TVALID[k]               = log_full;
    assign log_TLAST[k]                = log_buf[DATA_WIDTH+KW];
  end

endmodule

// File: tb/tb_dbg_guv_multi.sv
// Directed bench for dbg_guv_multi (ADDR=3, NUM_CH=2, STICKY_MODE=0, PIPE_STAGE=0)
// with queue scoreboards for forwarded commands, stream output and log output.
module tb_dbg_guv_multi;
  localparam int DW = 32, DEW = 16, IW = 16, CS = 16, AW = 10, NCH = 2, KW = DW / 8;
  localparam int LOG_W = DW + KW + 1 + DEW + IW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [DW-1:0]       cmd_in_TDATA = '0;
  logic                cmd_in_TVALID = 1'b0;
  logic [DW-1:0]       cmd_out_TDATA;
  logic                cmd_out_TVALID;
  logic [NCH*DW-1:0]   in_TDATA = '0;
  logic [NCH*KW-1:0]   in_TKEEP = '1;
  logic [NCH*DEW-1:0]  in_TDEST = '0;
  logic [NCH*IW-1:0]   in_TID = '0;
  logic [NCH-1:0]      in_TLAST = '0;
  logic [NCH-1:0]      in_TVALID = '0;
  logic [NCH-1:0]      in_TREADY;
  logic [NCH*DW-1:0]   out_TDATA;
  logic [NCH*KW-1:0]   out_TKEEP;
  logic [NCH*DEW-1:0]  out_TDEST;
  logic [NCH*IW-1:0]   out_TID;
  logic [NCH-1:0]      out_TLAST;
  logic [NCH-1:0]      out_TVALID;
  logic [NCH-1:0]      out_TREADY = '1;
  logic [NCH*LOG_W-1:0] log_TDATA;
  logic [NCH-1:0]      log_TLAST;
  logic [NCH-1:0]      log_TVALID;
  logic [NCH-1:0]      log_TREADY = '1;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] cmdq[$];
  logic [DW-1:0] outq[$];
  logic [DW-1:0] logq[$];

  dbg_guv_multi #(
    .DATA_WIDTH(DW), .DEST_WIDTH(DEW), .ID_WIDTH(IW), .CNT_SIZE(CS),
    .ADDR_WIDTH(AW), .ADDR(3), .NUM_CH(NCH), .STICKY_MODE(0), .PIPE_STAGE(0)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_in_TDATA(cmd_in_TDATA), .cmd_in_TVALID(cmd_in_TVALID),
    .cmd_out_TDATA(cmd_out_TDATA), .cmd_out_TVALID(cmd_out_TVALID),
    .in_TDATA(in_TDATA), .in_TKEEP(in_TKEEP), .in_TDEST(in_TDEST), .in_TID(in_TID),
    .in_TLAST(in_TLAST), .in_TVALID(in_TVALID), .in_TREADY(in_TREADY),
    .out_TDATA(out_TDATA), .out_TKEEP(out_TKEEP), .out_TDEST(out_TDEST), .out_TID(out_TID),
    .out_TLAST(out_TLAST), .out_TVALID(out_TVALID), .out_TREADY(out_TREADY),
    .log_TDATA(log_TDATA), .log_TLAST(log_TLAST), .log_TVALID(log_TVALID),
    .log_TREADY(log_TREADY)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input string tag, inout logic [DW-1:0] q[$], input logic [DW-1:0] obs);
    if (q.size() == 0) chk({tag, "_queue_empty"}, 64'(q.size()), 64'd1);
    else chk(tag, 64'(obs), 64'(q.pop_front()));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] hdr(input int a, input int c, input int r);
    return DW'((a << 6) | (c << 4) | r);
  endfunction

  // Our commands must never appear on cmd_out.
  task automatic send_cmd(input logic [DW-1:0] h, input logic [DW-1:0] v);
    step();
    cmd_in_TDATA = h;
    cmd_in_TVALID = 1'b1;
    @(negedge clk);
    chk("cmd_hdr_consumed", 64'(cmd_out_TVALID), 64'd0);
    step();
    cmd_in_TDATA = v;
    @(negedge clk);
    chk("cmd_val_consumed", 64'(cmd_out_TVALID), 64'd0);
    step();
    cmd_in_TVALID = 1'b0;
    cmd_in_TDATA = '0;
  endtask

  task automatic wr(input int c, input int r, input int v);
    send_cmd(hdr(3, c, r), DW'(v));
  endtask

  initial begin
    int dcnt;
    logic exp_v;
    logic [DW-1:0] d;

    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    @(negedge clk);
    chk("rst_cmd_out_valid", 64'(cmd_out_TVALID), 64'd0);
    chk("rst_log_valid", 64'(log_TVALID), 64'd0);
    chk("rst_in_ready", 64'(in_TREADY), 64'h3);
    chk("rst_out_valid", 64'(out_TVALID), 64'd0);

    step();
    in_TVALID = 2'b11;
    in_TDATA = {32'h1111_2222, 32'h3333_4444};
    in_TDEST = {16'hBEEF, 16'hCAFE};
    @(negedge clk);
    chk("pass_out_valid", 64'(out_TVALID), 64'h3);
    chk("pass_out_data", 64'(out_TDATA), 64'h1111_2222_3333_4444);
    chk("pass_out_dest", 64'(out_TDEST), 64'hBEEF_CAFE);

    wr(1, 2, 1);
    @(negedge clk);
    chk("pause_before_latch", 64'(out_TVALID), 64'h3);
    wr(1, 15, 0);
    @(negedge clk);
    chk("pause_in_ready", 64'(in_TREADY), 64'h1);
    chk("pause_out_valid", 64'(out_TVALID), 64'h1);
    wr(1, 2, 0);
    wr(1, 15, 0);
    @(negedge clk);
    chk("unpause_in_ready", 64'(in_TREADY), 64'h3);
    chk("unpause_out_valid", 64'(out_TVALID), 64'h3);

    step();
    cmd_in_TDATA = hdr(5, 1, 2);
    cmd_in_TVALID = 1'b1;
    cmdq.push_back(hdr(5, 1, 2));
    @(negedge clk);
    chk("fwd_hdr_valid", 64'(cmd_out_TVALID), 64'd1);
    pop_chk("fwd_hdr_data", cmdq, cmd_out_TDATA);
    step();
    cmd_in_TDATA = 32'hAB;
    cmdq.push_back(32'hAB);
    @(negedge clk);
    chk("fwd_val_valid", 64'(cmd_out_TVALID), 64'd1);
    pop_chk("fwd_val_data", cmdq, cmd_out_TDATA);
    step();
    cmd_in_TVALID = 1'b0;
    @(negedge clk);
    chk("fwd_idle_valid", 64'(cmd_out_TVALID), 64'd0);
    wr(1, 15, 0);
    @(negedge clk);
    chk("fwd_no_reg_change", 64'(out_TVALID), 64'h3);

    step();
    in_TVALID = 2'b00;
    wr(0, 0, 3);
    wr(0, 15, 0);
    dcnt = 3;
    for (int i = 0; i < 6; i++) begin
      d = DW'(2 * i);
      step();
      in_TVALID[0] = 1'b1;
      in_TDATA[DW-1:0] = d;
      exp_v = (dcnt == 0);
      if (exp_v) outq.push_back(d);
      else dcnt--;
      @(negedge clk);
      chk("drop_in_ready", 64'(in_TREADY[0]), 64'd1);
      chk("drop_out_valid", 64'(out_TVALID[0]), 64'(exp_v));
      if (exp_v) pop_chk("drop_out_data", outq, out_TDATA[DW-1:0]);
    end
    chk("drop_queue_drained", 64'(outq.size()), 64'd0);

    step();
    in_TVALID = 2'b00;
    log_TREADY[0] = 1'b0;
    wr(0, 1, 2);
    wr(0, 15, 0);
    step();
    in_TVALID[0] = 1'b1;
    in_TDATA[DW-1:0] = 32'd0;
    in_TLAST[0] = 1'b0;
    logq.push_back(32'd0);
    outq.push_back(32'd0);
    @(negedge clk);
    chk("log0_out_valid", 64'(out_TVALID[0]), 64'd1);
    pop_chk("log0_out_data", outq, out_TDATA[DW-1:0]);
    chk("log0_log_valid", 64'(log_TVALID[0]), 64'd0);
    step();
    in_TDATA[DW-1:0] = 32'd2;
    in_TLAST[0] = 1'b1;
    @(negedge clk);
    chk("log_stall_out_valid", 64'(out_TVALID[0]), 64'd0);
    chk("log_stall_in_ready", 64'(in_TREADY[0]), 64'd0);
    chk("log0_log_valid_up", 64'(log_TVALID[0]), 64'd1);
    pop_chk("log0_log_data", logq, log_TDATA[DW-1:0]);
    step();
    @(negedge clk);
    chk("log_stall_hold", 64'(out_TVALID[0]), 64'd0);
    step();
    log_TREADY[0] = 1'b1;
    logq.push_back(32'd2);
    outq.push_back(32'd2);
    @(negedge clk);
    chk("log1_out_valid", 64'(out_TVALID[0]), 64'd1);
    chk("log1_in_ready", 64'(in_TREADY[0]), 64'd1);
    pop_chk("log1_out_data", outq, out_TDATA[DW-1:0]);
    step();
    in_TVALID[0] = 1'b0;
    log_TREADY[0] = 1'b0;
    @(negedge clk);
    chk("log1_log_valid", 64'(log_TVALID[0]), 64'd1);
    pop_chk("log1_log_data", logq, log_TDATA[DW-1:0]);
    chk("log1_log_last", 64'(log_TLAST[0]), 64'd1);
    chk("log1_packed_last", 64'(log_TDATA[DW+KW]), 64'd1);
    step();
    log_TREADY[0] = 1'b1;
    @(negedge clk);
    chk("log_drain_pending", 64'(log_TVALID[0]), 64'd1);
    step();
    @(negedge clk);
    chk("log_drained", 64'(log_TVALID[0]), 64'd0);
    step();
    in_TVALID[0] = 1'b1;
    in_TDATA[DW-1:0] = 32'd4;
    log_TREADY[0] = 1'b0;
    @(negedge clk);
    chk("log_cnt_spent_out_valid", 64'(out_TVALID[0]), 64'd1);
    step();
    in_TVALID[0] = 1'b0;
    @(negedge clk);
    chk("log_cnt_spent_no_log", 64'(log_TVALID[0]), 64'd0);

    step();
    in_TVALID = 2'b11;
    log_TREADY = 2'b11;
    wr(3, 4, 1);
    wr(3, 15, 0);
    @(negedge clk);
    chk("bcast_in_ready", 64'(in_TREADY), 64'h3);
    chk("bcast_out_valid", 64'(out_TVALID), 64'h0);
    wr(3, 15, 0);
    @(negedge clk);
    chk("bcast_cleared_out_valid", 64'(out_TVALID), 64'h3);
    wr(2, 2, 1);
    wr(2, 15, 0);
    @(negedge clk);
    chk("ch_out_of_range_ignored", 64'(out_TVALID), 64'h3);
    wr(0, 7, 1);
    wr(0, 15, 0);
    @(negedge clk);
    chk("bad_reg_ignored", 64'(out_TVALID), 64'h3);

    wr(0, 2, 1);
    wr(0, 15, 0);
    @(negedge clk);
    chk("pre_reset_paused", 64'(in_TREADY), 64'h2);
    step();
    cmd_in_TDATA = hdr(3, 1, 2);
    cmd_in_TVALID = 1'b1;
    step();
    cmd_in_TVALID = 1'b0;
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", 64'(in_TREADY), 64'h3);
    chk("midrst_out_valid", 64'(out_TVALID), 64'h3);
    chk("midrst_log_valid", 64'(log_TVALID), 64'h0);
    chk("midrst_cmd_out_valid", 64'(cmd_out_TVALID), 64'd0);
    step();
    cmd_in_TDATA = 32'h1;
    cmd_in_TVALID = 1'b1;
    cmdq.push_back(32'h1);
    @(negedge clk);
    chk("midrst_parsed_as_hdr", 64'(cmd_out_TVALID), 64'd1);
    pop_chk("midrst_fwd_data", cmdq, cmd_out_TDATA);
    step();
    cmd_in_TDATA = 32'h2;
    cmdq.push_back(32'h2);
    @(negedge clk);
    chk("midrst_theirs_valid", 64'(cmd_out_TVALID), 64'd1);
    pop_chk("midrst_theirs_data", cmdq, cmd_out_TDATA);
    step();
    cmd_in_TVALID = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
